uart_rx_frame: RTL and testbench

- Serial receiver for the lab UART link. Sits directly downstream of the transmitter's Tx line.
- Recovers the team's 12-bit frame, sent LSB first: start(0), parity, d0..d7, stop(1), stop(1).
- Checks the frame and presents one byte per frame with a one-cycle valid strobe to the LED/consumer logic.
- Samples at 16x the baud rate, mid-bit, from the 50 MHz system clock.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_frame.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the lab UART link (12-bit frame: start, parity, d0..d7, 2 stops).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PARITY,
    DATA,
    STOP1,
    STOP2,
    BREAK
  } state_t;

  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned STOP_BITS  = 2;
  // Frame minus start, parity and stop bits
  localparam int unsigned DATA_BITS  = FRAME_BITS - 2 - STOP_BITS;

  // Clocks per oversample tick, rounded to nearest
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider producing a one-clk tick every DIV clocks; clr_i restarts it at 0.
module uart_baud_tick #(
  parameter int unsigned DIV = 326
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + TW'(1);
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x oversampled, mid-bit sampling, even parity and stop-bit checking.
// Optional UART_RX_MAJORITY_EN: each bit decided by majority of three samples around mid-bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OVS    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int unsigned SW  = $clog2(OVS);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_PRE  = SW'(OVS / 2 - 2);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_POST = SW'(OVS / 2);
`else
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
`endif

  // Line synchronizer and edge history; reset to idle-high so reset release is not a start edge
  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  logic fall_c;
  assign fall_c = rx_prev_q & ~rx_s_q;

  logic clr_c;
  logic tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_c),
    .tick_o (tick)
  );

  state_t                 state_q, state_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [STOP_BITS-2:0]   stop_q, stop_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  logic bit_evt_c;
  logic bit_val_c;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // Two early samples held, third taken live at the decision tick
  always_comb begin
    maj_d = maj_q;
    if (tick && (state_q != IDLE) && (samp_q == S_PRE || samp_q == S_MID)) begin
      maj_d = {maj_q[0], rx_s_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_q <= 2'b11;
    end else begin
      maj_q <= maj_d;
    end
  end

  assign bit_evt_c = tick && (samp_q == S_POST);
  assign bit_val_c = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s_q) | (maj_q[0] & rx_s_q);
`else
  assign bit_evt_c = tick && (samp_q == S_MID);
  assign bit_val_c = rx_s_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    clr_c   = 1'b0;

    if ((state_q != IDLE) && tick) begin
      samp_d = samp_q + SW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          samp_d  = '0;
          idx_d   = '0;
          clr_c   = 1'b1;
        end
      end
      START: begin
        if (bit_evt_c) begin
          state_d = bit_val_c ? IDLE : PARITY;
        end
      end
      PARITY: begin
        if (bit_evt_c) begin
          par_d   = bit_val_c;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_evt_c) begin
          shift_d[idx_q] = bit_val_c;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP1;
          end
        end
      end
      STOP1: begin
        if (bit_evt_c) begin
          stop_d[0] = bit_val_c;
          state_d   = STOP2;
        end
      end
      STOP2: begin
        // Errors are flagged alongside the byte, never suppress it
        if (bit_evt_c) begin
          data_d  = shift_q;
          perr_d  = ^{shift_q, par_q};
          ferr_d  = ~&{stop_q, bit_val_c};
          valid_d = 1'b1;
          state_d = bit_val_c ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at a scaled-down baud (DIV=4, 64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ   = 1_600_000;
  localparam int unsigned BAUD     = 25_000;
  localparam int unsigned OVS      = 16;
  localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  uart_rx_frame #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         n_pass   = 0;
  int         n_checks = 0;
  int         vcount   = 0;
  longint     cyc      = 0;
  longint     vcyc[$];
  logic [7:0] vdata[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vcyc.push_back(cyc);
      vdata.push_back(data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Frame vector, index 0 is transmitted first
  function automatic logic [FRAME_BITS-1:0] mk(input logic [7:0] d, input logic par,
                                                input logic s1, input logic s2);
    return {s2, s1, d, par, 1'b0};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [FRAME_BITS-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_glitchy(input logic [FRAME_BITS-1:0] f);
    for (int i = 0; i < int'(FRAME_BITS); i++) begin
      rx = f[i];
      if (i >= 2 && i < 10) begin
        wait_clks(34);
        rx = ~f[i];
        wait_clks(4);
        rx = f[i];
        wait_clks(BIT_CLKS - 38);
      end else begin
        wait_clks(BIT_CLKS);
      end
    end
  endtask

  int     v0;
  int     q0;
  longint gap;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);

    // Clean frame 0xD2, even parity 0
    v0 = vcount;
    send_bits(mk(8'hD2, 1'b0, 1'b1, 1'b1), 3);
    check("d2_busy_mid", 32'(busy), 32'h1);
    send_bits(mk(8'hD2, 1'b0, 1'b1, 1'b1) >> 3, FRAME_BITS - 3);
    wait_clks(2 * BIT_CLKS);
    check("d2_count", 32'(vcount - v0), 32'd1);
    check("d2_data", 32'(data), 32'hD2);
    check("d2_perr", 32'(parity_err), 32'h0);
    check("d2_ferr", 32'(frame_err), 32'h0);
    check("d2_busy_after", 32'(busy), 32'h0);

    // 0xA5 has even parity 0; send 1
    v0 = vcount;
    send_bits(mk(8'hA5, 1'b1, 1'b1, 1'b1), FRAME_BITS);
    wait_clks(2 * BIT_CLKS);
    check("a5_count", 32'(vcount - v0), 32'd1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_perr", 32'(parity_err), 32'h1);
    check("a5_ferr", 32'(frame_err), 32'h0);

    // False start: 5/16 bit low
    v0 = vcount;
    rx = 1'b0;
    wait_clks(BIT_CLKS * 5 / 16);
    check("fs_busy_low", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("fs_busy_after", 32'(busy), 32'h0);
    check("fs_count", 32'(vcount - v0), 32'd0);
    check("fs_data_held", 32'(data), 32'hA5);

    // 0x3C with both stops low, line stays low into a break
    v0 = vcount;
    send_bits(mk(8'h3C, 1'b0, 1'b0, 1'b0), FRAME_BITS);
    rx = 1'b0;
    wait_clks(3 * BIT_CLKS);
    check("3c_count", 32'(vcount - v0), 32'd1);
    check("3c_data", 32'(data), 32'h3C);
    check("3c_ferr", 32'(frame_err), 32'h1);
    check("3c_perr", 32'(parity_err), 32'h0);
    check("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("brk_busy_after", 32'(busy), 32'h0);
    check("brk_count", 32'(vcount - v0), 32'd1);

    v0 = vcount;
    send_bits(mk(8'h81, 1'b0, 1'b1, 1'b1), FRAME_BITS);
    wait_clks(2 * BIT_CLKS);
    check("81_count", 32'(vcount - v0), 32'd1);
    check("81_data", 32'(data), 32'h81);
    check("81_ferr", 32'(frame_err), 32'h0);

    // Reset in the middle of data bit 4 of 0x55
    v0 = vcount;
    send_bits(mk(8'h55, 1'b0, 1'b1, 1'b1), 6);
    rx = 1'b1;
    wait_clks(BIT_CLKS / 2);
    rst = 1'b1;
    #1;
    check("mrst_data", 32'(data), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_valid", 32'(valid), 32'h0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    check("mrst_count", 32'(vcount - v0), 32'd0);
    send_bits(mk(8'h55, 1'b0, 1'b1, 1'b1), FRAME_BITS);
    wait_clks(2 * BIT_CLKS);
    check("55_count", 32'(vcount - v0), 32'd1);
    check("55_data", 32'(data), 32'h55);
    check("55_perr", 32'(parity_err), 32'h0);

    // Back-to-back 0x01 and 0xFE, zero idle gap
    v0 = vcount;
    q0 = vdata.size();
    send_bits(mk(8'h01, 1'b1, 1'b1, 1'b1), FRAME_BITS);
    send_bits(mk(8'hFE, 1'b1, 1'b1, 1'b1), FRAME_BITS);
    wait_clks(2 * BIT_CLKS);
    check("b2b_count", 32'(vcount - v0), 32'd2);
    if (vdata.size() >= q0 + 2) begin
      gap = vcyc[q0 + 1] - vcyc[q0];
      check("b2b_data0", 32'(vdata[q0]), 32'h01);
      check("b2b_data1", 32'(vdata[q0 + 1]), 32'hFE);
      check("b2b_gap", 32'(gap), 32'(FRAME_BITS * BIT_CLKS));
    end else begin
      check("b2b_pulses_seen", 32'(vdata.size() - q0), 32'd2);
    end
    check("b2b_perr", 32'(parity_err), 32'h0);

`ifdef UART_RX_MAJORITY_EN
    // One-tick glitch inside every data bit must be voted out
    v0 = vcount;
    q0 = vdata.size();
    send_glitchy(mk(8'h01, 1'b1, 1'b1, 1'b1));
    send_glitchy(mk(8'hFE, 1'b1, 1'b1, 1'b1));
    wait_clks(2 * BIT_CLKS);
    check("maj_count", 32'(vcount - v0), 32'd2);
    if (vdata.size() >= q0 + 2) begin
      check("maj_data0", 32'(vdata[q0]), 32'h01);
      check("maj_data1", 32'(vdata[q0 + 1]), 32'hFE);
    end else begin
      check("maj_pulses_seen", 32'(vdata.size() - q0), 32'd2);
    end
    check("maj_perr", 32'(parity_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
